// File: rtl/frame_uart_tx_pkg.sv
// Shared line levels, FSM encodings and the checksum helper for the game-state
// frame transmitter.
package frame_uart_tx_pkg;

    localparam logic UART_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // 100 MHz system clock at 115200 baud.
    localparam int DEFAULT_CLKS_PER_BIT = 868;

    typedef enum logic [1:0] {
        FS_IDLE    = 2'd0,
        FS_SYNC    = 2'd1,
        FS_PAYLOAD = 2'd2,
        FS_CSUM    = 2'd3
    } frame_state_e;

    typedef enum logic [1:0] {
        BS_IDLE  = 2'd0,
        BS_START = 2'd1,
        BS_DATA  = 2'd2,
        BS_STOP  = 2'd3
    } bit_state_e;

    // Running payload checksum: 8-bit sum, carries discarded.
    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 bit timing for one byte. ready is high while idle and during the last
// cycle of a stop bit, so a load then chains the next byte with no idle gap.
module uart_byte_tx
    import frame_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] data,
    output logic       txd,
    output logic       ready
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    bit_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             txd_q, txd_d;
    logic             tick;

    always_comb begin
        tick    = (cnt_q == CNT_LAST);
        ready   = (state_q == BS_IDLE) || ((state_q == BS_STOP) && tick);
        state_d = state_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        txd_d   = txd_q;
        if (state_q == BS_IDLE || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (load && ready) begin
            state_d = BS_START;
            cnt_d   = '0;
            bit_d   = '0;
            shift_d = data;
            txd_d   = START_BIT;
        end else if (tick) begin
            case (state_q)
                BS_START: begin
                    state_d = BS_DATA;
                    txd_d   = shift_q[0];
                end
                BS_DATA: begin
                    if (bit_q == 3'd7) begin
                        state_d = BS_STOP;
                        txd_d   = STOP_BIT;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        txd_d   = shift_q[1];
                    end
                end
                BS_STOP: begin
                    state_d = BS_IDLE;
                    txd_d   = UART_IDLE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BS_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            txd_q   <= UART_IDLE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
        end
    end

    assign txd = txd_q;

endmodule

// File: rtl/frame_uart_tx.sv
// Frame sequencer: latches a payload on send, then streams sync byte, payload
// bytes (byte 0 first) and an optional 8-bit sum through uart_byte_tx.
module frame_uart_tx
    import frame_uart_tx_pkg::*;
#(
    parameter int          CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int          NUM_BYTES    = 22,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
    parameter int          CHECKSUM_EN  = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [8*NUM_BYTES-1:0] frame,
    input  logic                   send,
    output logic                   busy,
    output logic                   done,
    output logic                   TxD
);

    localparam int IDX_W = $clog2(NUM_BYTES + 1);
    localparam logic [IDX_W-1:0] IDX_END = IDX_W'(NUM_BYTES);

    frame_state_e           state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [7:0]             csum_q, csum_d;
    logic [8*NUM_BYTES-1:0] shadow_q, shadow_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic                   tx_load;
    logic [7:0]             tx_data;
    logic                   tx_ready;
    logic [7:0]             pay_byte;

    always_comb begin
        pay_byte = '0;
        for (int k = 0; k < NUM_BYTES; k++) begin
            if (idx_q == IDX_W'(k)) begin
                pay_byte = shadow_q[8*k +: 8];
            end
        end
    end

    // The load is combinational so the byte engine drops TxD on the very edge
    // that accepts send or ends the previous stop bit.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        csum_d   = csum_q;
        shadow_d = shadow_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        tx_load  = 1'b0;
        tx_data  = SYNC_BYTE;

        case (state_q)
            FS_IDLE: begin
                if (send && tx_ready) begin
                    shadow_d = frame;
                    csum_d   = '0;
                    idx_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = FS_SYNC;
                    tx_load  = 1'b1;
                    tx_data  = SYNC_BYTE;
                end
            end
            FS_SYNC, FS_PAYLOAD: begin
                if (tx_ready) begin
                    if (idx_q != IDX_END) begin
                        tx_load = 1'b1;
                        tx_data = pay_byte;
                        csum_d  = csum_add(csum_q, pay_byte);
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = FS_PAYLOAD;
                    end else if (CHECKSUM_EN != 0) begin
                        tx_load = 1'b1;
                        tx_data = csum_q;
                        state_d = FS_CSUM;
                    end else begin
                        state_d = FS_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            FS_CSUM: begin
                if (tx_ready) begin
                    state_d = FS_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = FS_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= FS_IDLE;
            idx_q    <= '0;
            csum_q   <= '0;
            shadow_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            csum_q   <= csum_d;
            shadow_q <= shadow_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    uart_byte_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte_tx (
        .clk  (clk),
        .rst  (rst),
        .load (tx_load),
        .data (tx_data),
        .txd  (TxD),
        .ready(tx_ready)
    );

    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_frame_uart_tx.sv
// Directed bench for frame_uart_tx at 4 clk/bit, 2 payload bytes, with and
// without the checksum byte; a line receiver decodes TxD on falling clock edges.
module tb_frame_uart_tx;

  localparam int CPB = 4;
  localparam int NB  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] frame;
  logic        send;
  logic        send_nc;
  logic        busy, done, txd;
  logic        busy_nc, done_nc, txd_nc;

  logic        rx_sel;
  logic        rx_txd, rx_busy, rx_done;

  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  int          last_fall_cyc = 0;
  int          last_done_cyc = 0;

  logic [7:0]  exp_q[$];

  frame_uart_tx #(
    .CLKS_PER_BIT(CPB), .NUM_BYTES(NB), .SYNC_BYTE(8'hA5), .CHECKSUM_EN(1)
  ) dut (
    .clk(clk), .rst(rst), .frame(frame), .send(send),
    .busy(busy), .done(done), .TxD(txd)
  );

  frame_uart_tx #(
    .CLKS_PER_BIT(CPB), .NUM_BYTES(NB), .SYNC_BYTE(8'hA5), .CHECKSUM_EN(0)
  ) dut_nc (
    .clk(clk), .rst(rst), .frame(frame), .send(send_nc),
    .busy(busy_nc), .done(done_nc), .TxD(txd_nc)
  );

  assign rx_txd  = rx_sel ? txd_nc  : txd;
  assign rx_busy = rx_sel ? busy_nc : busy;
  assign rx_done = rx_sel ? done_nc : done;

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // driver tasks
  task automatic pulse_send(input logic nc);
    @(negedge clk);
    if (nc) send_nc = 1'b1; else send = 1'b1;
    @(negedge clk);
    if (nc) send_nc = 1'b0; else send = 1'b0;
  endtask

  task automatic push_frame(input logic [15:0] f, input logic with_csum);
    logic [7:0] s;
    s = f[7:0] + f[15:8];
    exp_q.push_back(8'hA5);
    exp_q.push_back(f[7:0]);
    exp_q.push_back(f[15:8]);
    if (with_csum) exp_q.push_back(s);
  endtask

  // Receiver: samples each bit two cycles into its slot, then times done.
  task automatic rx_frame(input int nbytes, input int exp_len);
    int         waited;
    int         fall_cyc;
    int         bad_ctl;
    logic [9:0] bits;
    logic [7:0] exp_b;
    waited  = 0;
    bad_ctl = 0;
    while (rx_txd !== 1'b0 && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    if (rx_txd !== 1'b0) begin
      check("start_fall_seen", {31'd0, rx_txd}, 32'd0);
      return;
    end
    fall_cyc      = cyc;
    last_fall_cyc = cyc;
    check("busy_at_fall", {31'd0, rx_busy}, 32'd1);
    for (int j = 0; j < nbytes; j++) begin
      for (int m = 0; m < 10; m++) begin
        while (cyc < fall_cyc + CPB * (10 * j + m) + 2) begin
          @(negedge clk);
          if (rx_busy !== 1'b1 || rx_done !== 1'b0) bad_ctl++;
        end
        bits[m] = rx_txd;
      end
      exp_b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      check("byte_data", {24'd0, bits[8:1]}, {24'd0, exp_b});
      check("byte_framing", {30'd0, bits[9], bits[0]}, 32'd2);
    end
    while (rx_done !== 1'b1 && cyc < fall_cyc + exp_len + 20) begin
      @(negedge clk);
      if (rx_done !== 1'b1 && rx_busy !== 1'b1) bad_ctl++;
    end
    check("frame_len", cyc - fall_cyc, exp_len);
    check("busy_held", bad_ctl, 0);
    check("busy_low_at_done", {31'd0, rx_busy}, 32'd0);
    check("line_high_at_done", {31'd0, rx_txd}, 32'd1);
    last_done_cyc = cyc;
    @(negedge clk);
    check("done_one_cycle", {31'd0, rx_done}, 32'd0);
  endtask

  initial begin
    int         bad;
    int         prev_done;
    logic [15:0] f;

    rst     = 1'b1;
    send    = 1'b0;
    send_nc = 1'b0;
    frame   = 16'h0000;
    rx_sel  = 1'b0;

    // reset state
    @(negedge clk);
    check("rst_txd", {31'd0, txd}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // idle for 1000 cycles
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (txd !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
      if (txd_nc !== 1'b1 || busy_nc !== 1'b0 || done_nc !== 1'b0) bad++;
    end
    check("idle_quiet", bad, 0);

    // basic frame
    frame = 16'h3C01;
    push_frame(16'h3C01, 1'b1);
    pulse_send(1'b0);
    rx_frame(4, 160);

    // checksum wrap
    frame = 16'h02FF;
    push_frame(16'h02FF, 1'b1);
    pulse_send(1'b0);
    rx_frame(4, 160);

    // checksum disabled build
    rx_sel = 1'b1;
    push_frame(16'h02FF, 1'b0);
    pulse_send(1'b1);
    rx_frame(3, 120);
    rx_sel = 1'b0;

    // send held high, frame changed mid-flight, back-to-back second frame
    @(negedge clk);
    frame = 16'h1234;
    send  = 1'b1;
    push_frame(16'h1234, 1'b1);
    fork
      rx_frame(4, 160);
      begin
        repeat (50) @(negedge clk);
        frame = 16'hFFFF;
      end
    join
    check("b2b_line_low", {31'd0, txd}, 32'd0);
    prev_done = last_done_cyc;
    push_frame(16'hFFFF, 1'b1);
    fork
      rx_frame(4, 160);
      begin
        repeat (20) @(negedge clk);
        send = 1'b0;
      end
    join
    check("b2b_gap", last_fall_cyc - prev_done, 1);

    // async reset during payload byte 1 data bits
    frame = 16'h5A11;
    pulse_send(1'b0);
    bad = 0;
    while (txd !== 1'b0 && bad < 400) begin
      @(negedge clk);
      bad++;
    end
    check("abort_fall_seen", {31'd0, txd}, 32'd0);
    repeat (94) @(negedge clk);
    check("abort_pre_line", {31'd0, txd}, 32'd0);
    #2 rst = 1'b1;
    #1;
    check("abort_txd", {31'd0, txd}, 32'd1);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (done !== 1'b0 || txd !== 1'b1) bad++;
    end
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (done !== 1'b0 || txd !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("abort_quiet", bad, 0);
    frame = 16'h0102;
    push_frame(16'h0102, 1'b1);
    pulse_send(1'b0);
    rx_frame(4, 160);

    // random payloads
    for (int i = 0; i < 100; i++) begin
      f     = 16'($urandom_range(0, 65535));
      frame = f;
      push_frame(f, 1'b1);
      pulse_send(1'b0);
      rx_frame(4, 160);
    end

    check("exp_q_drained", exp_q.size(), 0);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
